// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH     = 4'd0;
    localparam state_t S_DECODE    = 4'd1;
    localparam state_t S_R_EXEC    = 4'd2;
    localparam state_t S_R_WB      = 4'd3;
    localparam state_t S_MEM_ADDR  = 4'd4;
    localparam state_t S_MEM_READ  = 4'd5;
    localparam state_t S_MEM_WB    = 4'd6;
    localparam state_t S_MEM_WRITE = 4'd7;
    localparam state_t S_BRANCH    = 4'd8;
    localparam state_t S_JUMP      = 4'd9;
    localparam state_t S_I_EXEC    = 4'd10;
    localparam state_t S_I_WB      = 4'd11;
    localparam state_t S_ILLEGAL   = 4'd12;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_FUNCT, AC_IMM} alu_class_t;
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps the FSM's ALU class plus opcode/funct to an ALU operation
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_op,
    output logic        bad_funct
);
    // funct is only meaningful for the R-type class; anything unknown there is flagged
    always_comb begin
        bad_funct = 1'b0;
        alu_op = ALU_ADD;
        case (cls)
            AC_SUB: alu_op = ALU_SUB;
            AC_IMM: alu_op = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            AC_FUNCT:
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    default: bad_funct = 1'b1;
                endcase
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state_o
);
    state_t state, next;
    alu_class_t cls;
    logic bad_funct;
    logic rdy;
    assign rdy = MEM_WAIT ? mem_ready : 1'b1;
    assign state_o = state;

    mips_alu_decoder u_alu_dec (
        .cls       (cls),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (alu_op),
        .bad_funct (bad_funct)
    );

    // state register; reset always lands in FETCH, abandoning any instruction in flight
    always_ff @(posedge clock) begin
        state <= reset ? S_FETCH : next;
    end

    // next-state: memory states hold until the access completes
    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:     next = rdy ? S_DECODE : S_FETCH;
            S_DECODE:    next = (opcode == OP_RTYPE) ? S_R_EXEC :
                                (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                                (opcode == OP_BEQ) ? S_BRANCH :
                                (opcode == OP_J) ? S_JUMP :
                                (opcode == OP_ADDI || opcode == OP_ORI) ? S_I_EXEC : S_ILLEGAL;
            S_R_EXEC:    next = bad_funct ? S_ILLEGAL : S_R_WB;
            S_MEM_ADDR:  next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next = rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: next = rdy ? S_FETCH : S_MEM_WRITE;
            S_I_EXEC:    next = S_I_WB;
            default:     next = S_FETCH;
        endcase
    end

    // outputs from the current state; enables and requests are suppressed while reset is high
    always_comb begin
        pc_we      = !reset && ((state == S_FETCH && rdy) || (state == S_BRANCH && zero) || state == S_JUMP);
        ir_we      = !reset && state == S_FETCH && rdy;
        reg_we     = !reset && (state inside {S_R_WB, S_MEM_WB, S_I_WB});
        mem_req    = !reset && (state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE});
        mem_we     = !reset && state == S_MEM_WRITE;
        illegal    = !reset && state == S_ILLEGAL;
        iord       = state inside {S_MEM_READ, S_MEM_WRITE};
        reg_dst    = state == S_R_WB;
        mem_to_reg = state == S_MEM_WB;
        alu_src_a  = state inside {S_R_EXEC, S_MEM_ADDR, S_BRANCH, S_I_EXEC};
        alu_src_b  = (state == S_FETCH) ? SRCB_FOUR :
                     (state == S_DECODE) ? SRCB_IMM_SH :
                     (state == S_MEM_ADDR || state == S_I_EXEC) ? SRCB_IMM : SRCB_B;
        pc_src     = (state == S_BRANCH) ? PCSRC_ALUOUT : (state == S_JUMP) ? PCSRC_JUMP : PCSRC_ALU;
        cls        = (state == S_R_EXEC) ? AC_FUNCT :
                     (state == S_BRANCH) ? AC_SUB :
                     (state == S_I_EXEC) ? AC_IMM : AC_ADD;
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed per-cycle vectors checked through an expectation queue
module tb_mips_multicycle_ctrl;
    localparam logic [3:0] FE = 4'd0, DE = 4'd1, RX = 4'd2, RW = 4'd3, MA = 4'd4, MR = 4'd5,
                           MW = 4'd6, WR = 4'd7, BR = 4'd8, JP = 4'd9, IX = 4'd10, IW = 4'd11, IL = 4'd12;
    localparam logic [5:0] EN_NONE = 6'b000000, EN_FETCH = 6'b110100, EN_MEM = 6'b000100,
                           EN_REG = 6'b001000, EN_WR = 6'b000110, EN_PC = 6'b100000, EN_ILL = 6'b000001;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110, A_SLT = 4'b0111;

    typedef struct packed {
        logic [3:0] st;
        logic pc_we, ir_we, reg_we, mem_req, mem_we, iord, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [3:0] alu_op;
        logic illegal;
    } exp_t;
    typedef struct packed {
        logic sel;
        int id;
        exp_t e;
    } item_t;

    logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic pc_we0, ir_we0, reg_we0, mem_req0, mem_we0, iord0, reg_dst0, mem_to_reg0, alu_src_a0, illegal0;
    logic pc_we1, ir_we1, reg_we1, mem_req1, mem_we1, iord1, reg_dst1, mem_to_reg1, alu_src_a1, illegal1;
    logic [1:0] alu_src_b0, pc_src0, alu_src_b1, pc_src1;
    logic [3:0] alu_op0, state0, alu_op1, state1;
    exp_t act0, act1;
    item_t q[$];
    int total = 0, bad = 0, nstep = 0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(.MEM_WAIT(1'b1)) dut0 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we0), .ir_we(ir_we0), .reg_we(reg_we0), .mem_req(mem_req0), .mem_we(mem_we0),
        .iord(iord0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .alu_src_a(alu_src_a0),
        .alu_src_b(alu_src_b0), .pc_src(pc_src0), .alu_op(alu_op0), .illegal(illegal0), .state_o(state0)
    );
    mips_multicycle_ctrl #(.MEM_WAIT(1'b0)) dut1 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we1), .ir_we(ir_we1), .reg_we(reg_we1), .mem_req(mem_req1), .mem_we(mem_we1),
        .iord(iord1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .pc_src(pc_src1), .alu_op(alu_op1), .illegal(illegal1), .state_o(state1)
    );

    assign act0 = {state0, pc_we0, ir_we0, reg_we0, mem_req0, mem_we0, iord0, reg_dst0, mem_to_reg0,
                   alu_src_a0, alu_src_b0, pc_src0, alu_op0, illegal0};
    assign act1 = {state1, pc_we1, ir_we1, reg_we1, mem_req1, mem_we1, iord1, reg_dst1, mem_to_reg1,
                   alu_src_a1, alu_src_b1, pc_src1, alu_op1, illegal1};

    // mux selects each state is documented to drive; everything else is 0
    function automatic exp_t tbl(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        case (st)
            FE: e.alu_src_b = 2'b01;
            DE: e.alu_src_b = 2'b11;
            RX: e.alu_src_a = 1'b1;
            RW: e.reg_dst = 1'b1;
            MA: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            MR: e.iord = 1'b1;
            MW: e.mem_to_reg = 1'b1;
            WR: e.iord = 1'b1;
            BR: begin e.alu_src_a = 1'b1; e.pc_src = 2'b01; end
            JP: e.pc_src = 2'b10;
            IX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            default: e.st = st;
        endcase
        return e;
    endfunction

    // drive one cycle's inputs and queue what the selected DUT must show in that cycle
    task automatic s(input logic r, rdy, z, input logic [5:0] op, fn, input logic [3:0] st,
                     input logic [5:0] en, input logic [3:0] aop, input logic sel);
        item_t it;
        @(posedge clock);
        #1;
        reset = r; mem_ready = rdy; zero = z; opcode = op; funct = fn;
        it.e = tbl(st);
        {it.e.pc_we, it.e.ir_we, it.e.reg_we, it.e.mem_req, it.e.mem_we, it.e.illegal} = en;
        it.e.alu_op = aop;
        it.sel = sel;
        it.id = nstep++;
        q.push_back(it);
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [3:0] aop);
        s(0, 1, 0, 6'b000000, fn, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b000000, fn, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000000, fn, RX, EN_NONE, aop, 0);
        s(0, 1, 0, 6'b000000, fn, RW, EN_REG, A_ADD, 0);
    endtask

    // monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clock) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t a;
            it = q.pop_front();
            a = it.sel ? act1 : act0;
            total++;
            if (a !== it.e) begin
                bad++;
                $display("FAIL step%0d dut%0d outs: got %h want %h", it.id, it.sel, a, it.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) s(1, 1, 0, 6'b000000, 6'b100010, FE, EN_NONE, A_ADD, 0);
        rtype(6'b100010, A_SUB);
        s(0, 0, 0, 6'b000000, 6'b100100, FE, EN_MEM, A_ADD, 0);
        rtype(6'b100100, A_AND);
        rtype(6'b100101, A_OR);
        rtype(6'b101010, A_SLT);
        rtype(6'b100000, A_ADD);
        s(0, 1, 0, 6'b100011, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b100011, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b100011, 0, MA, EN_NONE, A_ADD, 0);
        s(0, 0, 0, 6'b100011, 0, MR, EN_MEM, A_ADD, 0);
        s(0, 0, 0, 6'b100011, 0, MR, EN_MEM, A_ADD, 0);
        s(0, 1, 0, 6'b100011, 0, MR, EN_MEM, A_ADD, 0);
        s(0, 1, 0, 6'b100011, 0, MW, EN_REG, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, MA, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, WR, EN_WR, A_ADD, 0);
        s(0, 1, 0, 6'b000100, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b000100, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000100, 0, BR, EN_NONE, A_SUB, 0);
        s(0, 1, 1, 6'b000100, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 1, 6'b000100, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 1, 6'b000100, 0, BR, EN_PC, A_SUB, 0);
        s(0, 1, 0, 6'b000010, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b000010, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000010, 0, JP, EN_PC, A_ADD, 0);
        s(0, 1, 0, 6'b001000, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b001000, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b001000, 0, IX, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b001000, 0, IW, EN_REG, A_ADD, 0);
        s(0, 1, 0, 6'b001101, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b001101, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b001101, 0, IX, EN_NONE, A_OR, 0);
        s(0, 1, 0, 6'b001101, 0, IW, EN_REG, A_ADD, 0);
        s(0, 1, 0, 6'b111111, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b111111, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b111111, 0, IL, EN_ILL, A_ADD, 0);
        s(0, 1, 0, 6'b000000, 6'b000111, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b000000, 6'b000111, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000000, 6'b000111, RX, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000000, 6'b000111, IL, EN_ILL, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b101011, 0, MA, EN_NONE, A_ADD, 0);
        s(0, 0, 0, 6'b101011, 0, WR, EN_WR, A_ADD, 0);
        s(1, 0, 0, 6'b101011, 0, WR, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000010, 0, FE, EN_FETCH, A_ADD, 0);
        s(0, 1, 0, 6'b000010, 0, DE, EN_NONE, A_ADD, 0);
        s(0, 1, 0, 6'b000010, 0, JP, EN_PC, A_ADD, 0);
        s(1, 1, 0, 6'b101011, 0, FE, EN_NONE, A_ADD, 0);
        s(1, 0, 0, 6'b101011, 0, FE, EN_NONE, A_ADD, 1);
        s(0, 0, 0, 6'b101011, 0, FE, EN_FETCH, A_ADD, 1);
        s(0, 0, 0, 6'b101011, 0, DE, EN_NONE, A_ADD, 1);
        s(0, 0, 0, 6'b101011, 0, MA, EN_NONE, A_ADD, 1);
        s(0, 0, 0, 6'b101011, 0, WR, EN_WR, A_ADD, 1);
        s(0, 0, 0, 6'b100011, 0, FE, EN_FETCH, A_ADD, 1);
        s(0, 0, 0, 6'b100011, 0, DE, EN_NONE, A_ADD, 1);
        s(0, 0, 0, 6'b100011, 0, MA, EN_NONE, A_ADD, 1);
        s(0, 0, 0, 6'b100011, 0, MR, EN_MEM, A_ADD, 1);
        s(0, 0, 0, 6'b100011, 0, MW, EN_REG, A_ADD, 1);
        s(0, 0, 0, 6'b000010, 0, FE, EN_FETCH, A_ADD, 1);
        @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, memory treated as single-cycle.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 funct  input  6  IR[5:0], used only for R-type.
REQ-006 zero  input  1  ALU zero flag, same cycle.
REQ-007 mem_ready  input  1  memory completion for the current mem_req.
REQ-008 pc_we, ir_we, reg_we, mem_req, mem_we  output  1 each  PC, IR, regfile write; memory request, memory write.
REQ-009 iord, reg_dst, mem_to_reg, alu_src_a  output  1 each  address select (0 PC, 1 ALUOut); dest (0 rt, 1 rd); writeback (0 ALUOut, 1 MDR); ALU A (0 PC, 1 A).
REQ-010 alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}.
REQ-012 alu_op  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-013 illegal  output  1  one-cycle pulse on unsupported opcode/funct.
REQ-014 state_o  output  4  current state encoding, debug only.

Function
REQ-015 Moore FSM; outputs decoded from current state only (pc_we in BRANCH also uses zero); every output not listed for a state is 0, alu_op otherwise ADD.
REQ-016 FETCH: mem_req=1, iord=0, ir_we, alu_src_a=0, alu_src_b=01, pc_src=00; ir_we and pc_we assert only in the cycle mem_ready=1 (or always when MEM_WAIT=0); then -> DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target to ALUOut); next by opcode: 000000 R_EXEC, 100011/101011 MEM_ADDR, 000100 BRANCH, 000010 JUMP, 001000 I_EXEC, 001101 I_EXEC; any other -> ILLEGAL.
REQ-018 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT); unsupported funct -> ILLEGAL, else -> R_WB.
REQ-019 R_WB: reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD -> MEM_READ (lw) or MEM_WRITE (sw).
REQ-021 MEM_READ: mem_req=1, iord=1; waits while mem_ready=0 (MEM_WAIT=1); -> MEM_WB on ready.
REQ-022 MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-023 MEM_WRITE: mem_req=1, mem_we=1, iord=1; waits as REQ-021; -> FETCH on ready.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=zero -> FETCH.
REQ-025 JUMP: pc_src=10, pc_we=1 -> FETCH.
REQ-026 I_EXEC: alu_src_a=1, alu_src_b=10, ADD (addi) or OR (ori) -> I_WB; I_WB: reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-027 ILLEGAL: illegal=1 for exactly one cycle, no write enables -> FETCH.
REQ-028 Latency with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi/ori 4 cycles; each mem_ready=0 cycle adds one.
REQ-029 mem_req/mem_we/iord held stable while waiting; mem_ready high outside a memory state is ignored.

Reset
REQ-030 reset sampled at rising edge forces state FETCH; during any cycle with reset=1 all write enables, mem_req and illegal SHALL be 0.
REQ-031 Reset mid-instruction (incl. during memory wait) abandons it; no partial write completes; first cycle after release is FETCH.

Structure
REQ-032 Package mips_ctrl_pkg: state enum, opcode and funct constants, alu_op codes, mux select constants.
REQ-033 Sub-module mips_alu_decoder: combinational funct/opcode class -> alu_op, ILLEGAL on unsupported funct.

Verification
REQ-034 Reset 3 cycles, mem_ready=1 -> state_o=FETCH, pc_we=ir_we=1 first cycle after reset; no reg_we/mem_we.
REQ-035 opcode=000000 funct=100010, mem_ready=1 -> states FETCH,DECODE,R_EXEC,R_WB; alu_op=0110 in R_EXEC; reg_we=1,reg_dst=1 only in cycle 4.
REQ-036 lw (100011), mem_ready low 2 cycles in MEM_READ -> 7 cycles total, mem_req/iord steady, reg_we with mem_to_reg=1 in last cycle.
REQ-037 beq with zero=0 then zero=1 -> pc_we=0 resp. 1 in BRANCH, pc_src=01, 3 cycles each.
REQ-038 opcode=111111 -> illegal pulses 1 cycle, no write enables, back to FETCH; R-type funct=000111 same.
REQ-039 reset asserted during MEM_WRITE wait -> mem_we=0 that cycle, FETCH next; MEM_WAIT=0 run of sw takes 4 cycles regardless of mem_ready.
